// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder slice:
// FSM encodings, DRW meanings, data width and the address error check.
package dmem_responder_pkg;

  localparam int DATA_W      = 32;
  localparam int CNT_W       = 4;
  localparam int LATENCY_MAX = 15;

  localparam logic DRW_READ  = 1'b0;
  localparam logic DRW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // An access is in error when it is not word aligned or points past the store.
  function automatic logic addr_err(input logic [31:0] addr, input int addr_w);
    return (addr[1:0] != 2'b00) || ((addr >> (addr_w + 2)) != 32'd0);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage data bus: request/store side driven by the pipeline,
// completion/stall side driven by the memory responder.
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic              DREQ;
  logic              DRW;
  logic [31:0]       DADDR;
  logic [DATA_W-1:0] DWDATA;
  logic [DATA_W-1:0] DRDATA;
  logic              DVALID;
  logic              DERR;
  logic              DSTALL;

  modport master (
    output DREQ, DRW, DADDR, DWDATA,
    input  DRDATA, DVALID, DERR, DSTALL
  );

  modport slave (
    input  DREQ, DRW, DADDR, DWDATA,
    output DRDATA, DVALID, DERR, DSTALL
  );

endinterface

// File: rtl/dmem_responder_array.sv
// Single-port word store with synchronous write and enabled, registered read.
// Contents and read register are deliberately left unreset.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  // The read register only moves on i_re so a completed load stays visible.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
    if (i_re) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave: latches a load/store, waits LATENCY cycles, then
// completes with a one-cycle DVALID; bad addresses complete with DERR.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int LATENCY = 2
) (
  input  logic              CLK,
  input  logic              RSTN,
  dmem_responder_if.slave   bus
);

  localparam logic [CNT_W-1:0] LAT_M1 = (LATENCY == 0) ? '0 : CNT_W'(LATENCY - 1);

  if (LATENCY < 0 || LATENCY > LATENCY_MAX) begin : g_latency_check
    $error("dmem_responder: LATENCY must be within 0..15");
  end

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_next;
  logic              r_rw;
  logic [31:0]       r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_dvalid;
  logic              r_derr;
  logic              r_rd_valid;

  logic              w_accept;
  logic              w_enter_resp;
  logic              w_acc_rw;
  logic [31:0]       w_acc_addr;
  logic              w_err;
  logic [ADDR_W-1:0] w_index;
  logic              w_mem_we;
  logic              w_mem_re;
  logic [DATA_W-1:0] w_mem_rdata;

  assign w_accept     = (r_state == S_IDLE) && bus.DREQ;
  assign w_enter_resp = (w_state_next == S_RESP);

  // With zero latency RESP is entered on the accepting edge, before the
  // latches hold the request, so the live bus fields are used there.
  assign w_acc_rw   = w_accept ? bus.DRW   : r_rw;
  assign w_acc_addr = w_accept ? bus.DADDR : r_addr;
  assign w_err      = addr_err(w_acc_addr, ADDR_W);
  assign w_index    = w_acc_addr[ADDR_W+1:2];

  assign w_mem_re = w_enter_resp && (w_acc_rw == DRW_READ) && !w_err;
  assign w_mem_we = (r_state == S_RESP) && (r_rw == DRW_WRITE) && !r_derr;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (bus.DREQ) begin
          if (LATENCY == 0) begin
            w_state_next = S_RESP;
          end else begin
            w_state_next = S_WAIT;
            w_cnt_next   = LAT_M1;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == '0) begin
          w_state_next = S_RESP;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      S_RESP: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rw       <= DRW_READ;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_dvalid   <= 1'b0;
      r_derr     <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_dvalid <= w_enter_resp;
      if (w_accept) begin
        r_rw    <= bus.DRW;
        r_addr  <= bus.DADDR;
        r_wdata <= bus.DWDATA;
      end
      if (w_enter_resp) begin
        r_derr     <= w_err;
        r_rd_valid <= (w_acc_rw == DRW_READ) && !w_err;
      end else begin
        r_derr <= 1'b0;
      end
    end
  end

  dmem_array #(
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (CLK),
    .i_we    (w_mem_we),
    .i_re    (w_mem_re),
    .i_addr  (w_index),
    .i_wdata (r_wdata),
    .o_rdata (w_mem_rdata)
  );

  // DRDATA is zero after reset and for writes/errors; otherwise it shows the
  // last load until the next access completes.
  assign bus.DRDATA = r_rd_valid ? w_mem_rdata : '0;
  assign bus.DVALID = r_dvalid;
  assign bus.DERR   = r_derr;
  assign bus.DSTALL = bus.DREQ & (r_state != S_RESP);

endmodule
